// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
//
// Runs an exhaustive 4-vector functional test on a 2-input logic gate.
// For each vector index idx = {A,B} = 0..3 it drives A/B, waits
// SETTLE_CYCLES cycles for the gate to settle, then samples Y. Y is
// compared against TRUTH[idx], and each mismatching vector is counted.
// A one-cycle done pulse marks the end of a pass. pass reports whether
// that pass had zero mismatches.
//
// Parameters:
//   SETTLE_CYCLES  cycles waited between driving a vector and sampling Y (0..15)
//   TRUTH          expected Y per vector index (bit n <-> A=n[1], B=n[0])
//
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous active-high reset
//   start    request a test pass (only honoured while idle)
//   abort    terminate a running pass without a done pulse
//   Y        output of the gate under test
//   A, B     registered gate inputs; they hold their last value between passes
//   busy     high whenever a pass is in progress (any state but IDLE)
//   done     one-cycle pulse when a pass completes
//   pass     last completed pass had zero mismatches (cleared on start/abort)
//   err_cnt  mismatching vectors seen in the current/last pass
//
// Optional feature (macro GATE_TEST_SEQUENCER_ERRLOG_EN):
//   first_err_idx    vector index of the first mismatch in the pass
//   first_err_valid  a mismatch has been captured since the last start

module gate_test_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  TRUTH         = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
    ,
    output logic [1:0] first_err_idx,
    output logic       first_err_valid
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state_reg;
    logic [1:0] idx_reg;
    logic [3:0] settle_cnt_reg;

    logic       mismatch;
    logic [2:0] err_cnt_next;
    logic [1:0] idx_next;

    assign mismatch     = (Y != TRUTH[idx_reg]);
    assign err_cnt_next = err_cnt + {2'b00, mismatch};
    assign idx_next     = idx_reg + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= 2'd0;
            settle_cnt_reg <= 4'd0;
            A              <= 1'b0;
            B              <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= 3'd0;
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
            first_err_idx   <= 2'd0;
            first_err_valid <= 1'b0;
`endif
        end else begin
            // done is a pulse: only the SAMPLE->DONE transition raises it.
            done <= 1'b0;

            if (abort && (state_reg != IDLE)) begin
                // err_cnt and A/B deliberately keep their values.
                state_reg <= IDLE;
                busy      <= 1'b0;
                pass      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            state_reg <= APPLY;
                            idx_reg   <= 2'd0;
                            A         <= 1'b0;
                            B         <= 1'b0;
                            err_cnt   <= 3'd0;
                            pass      <= 1'b0;
                            busy      <= 1'b1;
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
                            first_err_idx   <= 2'd0;
                            first_err_valid <= 1'b0;
`endif
                        end
                    end

                    APPLY: begin
                        settle_cnt_reg <= SETTLE_LOAD;
                        state_reg      <= (SETTLE_CYCLES != 0) ? SETTLE : SAMPLE;
                    end

                    SETTLE: begin
                        // Counter enters holding SETTLE_CYCLES; leaving on 1
                        // makes the state last exactly that many cycles.
                        if (settle_cnt_reg != 4'd0) begin
                            settle_cnt_reg <= settle_cnt_reg - 4'd1;
                        end
                        if (settle_cnt_reg <= 4'd1) begin
                            state_reg <= SAMPLE;
                        end
                    end

                    SAMPLE: begin
                        err_cnt <= err_cnt_next;
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
                        if (mismatch && !first_err_valid) begin
                            first_err_idx   <= idx_reg;
                            first_err_valid <= 1'b1;
                        end
`endif
                        if (idx_reg == 2'd3) begin
                            // pass must include this final sample, so use
                            // the updated count rather than the register.
                            state_reg <= DONE;
                            done      <= 1'b1;
                            pass      <= (err_cnt_next == 3'd0);
                        end else begin
                            state_reg <= APPLY;
                            idx_reg   <= idx_next;
                            A         <= idx_next[1];
                            B         <= idx_next[0];
                        end
                    end

                    DONE: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end

                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer. Two instances: the default build
// (SETTLE_CYCLES=2, NAND truth) and a zero-settle AND-truth build.
// Each instance tests a simulated gate whose truth table the bench picks.
// Expected timing, A/B sequence, err_cnt and pass are derived from
// vector arithmetic on those tables.

module tb_gate_test_sequencer;

    localparam int         S0 = 2;
    localparam logic [3:0] T0 = 4'b0111;
    localparam int         S1 = 0;
    localparam logic [3:0] T1 = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start_s = 2'b00;
    logic [1:0] abort_s = 2'b00;
    logic [1:0] y_s;
    logic [1:0] a_s, b_s, busy_s, done_s, pass_s;
    logic [2:0] err_s [2];
    logic [3:0] gate_tt [2];
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
    logic [1:0] fei_s [2];
    logic [1:0] fev_s;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Simulated gates under test: Y is a lookup of the chosen truth table.
    assign y_s[0] = gate_tt[0][{a_s[0], b_s[0]}];
    assign y_s[1] = gate_tt[1][{a_s[1], b_s[1]}];

    gate_test_sequencer #(.SETTLE_CYCLES(S0), .TRUTH(T0)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .Y(y_s[0]),
        .A(a_s[0]), .B(b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .err_cnt(err_s[0])
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
        , .first_err_idx(fei_s[0]), .first_err_valid(fev_s[0])
`endif
    );

    gate_test_sequencer #(.SETTLE_CYCLES(S1), .TRUTH(T1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .Y(y_s[1]),
        .A(a_s[1]), .B(b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .err_cnt(err_s[1])
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
        , .first_err_idx(fei_s[1]), .first_err_valid(fev_s[1])
`endif
    );

    function automatic int settle_of(input int i);
        return (i == 1) ? S1 : S0;
    endfunction

    function automatic logic [3:0] truth_of(input int i);
        return (i == 1) ? T1 : T0;
    endfunction

    function automatic int first_set(input logic [3:0] v);
        for (int n = 0; n < 4; n++) begin
            if (v[n]) return n;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_i%0d_A", tag, i), 32'(a_s[i]), 0);
            check($sformatf("%s_i%0d_B", tag, i), 32'(b_s[i]), 0);
            check($sformatf("%s_i%0d_busy", tag, i), 32'(busy_s[i]), 0);
            check($sformatf("%s_i%0d_done", tag, i), 32'(done_s[i]), 0);
            check($sformatf("%s_i%0d_pass", tag, i), 32'(pass_s[i]), 0);
            check($sformatf("%s_i%0d_err", tag, i), 32'(err_s[i]), 0);
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
            check($sformatf("%s_i%0d_fev", tag, i), 32'(fev_s[i]), 0);
            check($sformatf("%s_i%0d_fei", tag, i), 32'(fei_s[i]), 0);
`endif
        end
    endtask

    // Starts a pass on instance i against gate table tt and follows it up
    // to cycle last_t (cycle 1 = first cycle after start is sampled),
    // returning at that cycle's falling edge. A pass occupies 4 vectors of
    // (settle+2) cycles each, followed by one done cycle.
    task automatic run(input int i, input logic [3:0] tt, input int last_t, input bit inject);
        int         s;
        int         d;
        int         k;
        logic [3:0] mm;
        s  = settle_of(i);
        d  = 4 * (s + 2) + 1;
        mm = tt ^ truth_of(i);
        gate_tt[i] = tt;
        @(negedge clk);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        for (int t = 1; t <= last_t; t++) begin
            if (t > 1) @(negedge clk);
            k = (t - 1) / (s + 2);
            if (k > 3) k = 3;
            check($sformatf("i%0d_t%0d_busy", i, t), 32'(busy_s[i]), (t <= d) ? 1 : 0);
            check($sformatf("i%0d_t%0d_done", i, t), 32'(done_s[i]), (t == d) ? 1 : 0);
            check($sformatf("i%0d_t%0d_A", i, t), 32'(a_s[i]), (k >> 1) & 1);
            check($sformatf("i%0d_t%0d_B", i, t), 32'(b_s[i]), k & 1);
            if (t == 1) begin
                check($sformatf("i%0d_t1_err_clr", i), 32'(err_s[i]), 0);
                check($sformatf("i%0d_t1_pass_clr", i), 32'(pass_s[i]), 0);
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
                check($sformatf("i%0d_t1_fev_clr", i), 32'(fev_s[i]), 0);
`endif
            end
            if (t >= d) begin
                check($sformatf("i%0d_t%0d_err", i, t), 32'(err_s[i]), $countones(mm));
                check($sformatf("i%0d_t%0d_pass", i, t), 32'(pass_s[i]), (mm == 4'd0) ? 1 : 0);
`ifdef GATE_TEST_SEQUENCER_ERRLOG_EN
                check($sformatf("i%0d_t%0d_fev", i, t), 32'(fev_s[i]), (mm != 4'd0) ? 1 : 0);
                if (mm != 4'd0)
                    check($sformatf("i%0d_t%0d_fei", i, t), 32'(fei_s[i]), first_set(mm));
`endif
            end
            // A start pulse while busy must be ignored.
            start_s[i] = (inject && t == 5) ? 1'b1 : 1'b0;
        end
        start_s[i] = 1'b0;
    endtask

    function automatic int full_len(input int i);
        return 4 * (settle_of(i) + 2) + 2;
    endfunction

    initial begin
        logic [3:0] mm;
        int         inst;
        gate_tt[0] = 4'b0111;
        gate_tt[1] = 4'b1000;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_released");

        // NAND gate against NAND truth: clean pass, done 17 cycles after start.
        run(0, 4'b0111, full_len(0), 1'b0);
        $display("pass: inst0 NAND gate, busy start injected=0");

        // Gate output stuck at 0: three mismatches, first at vector 0.
        run(0, 4'b0000, full_len(0), 1'b0);
        $display("pass: inst0 Y stuck at 0");

        // Zero settle, AND gate against AND truth: done 9 cycles after start.
        run(1, 4'b1000, full_len(1), 1'b1);
        $display("pass: inst1 AND gate, settle 0");

        // Abort during SETTLE of vector 2 (cycle 10 with settle=2).
        run(0, 4'b0110, 10, 1'b0);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        mm = 4'b0110 ^ T0;
        for (int n = 0; n < 3; n++) begin
            check($sformatf("abort_c%0d_busy", n), 32'(busy_s[0]), 0);
            check($sformatf("abort_c%0d_done", n), 32'(done_s[0]), 0);
            check($sformatf("abort_c%0d_pass", n), 32'(pass_s[0]), 0);
            check($sformatf("abort_c%0d_A", n), 32'(a_s[0]), 1);
            check($sformatf("abort_c%0d_B", n), 32'(b_s[0]), 0);
            check($sformatf("abort_c%0d_err", n), 32'(err_s[0]), $countones(mm[1:0]));
            @(negedge clk);
        end
        $display("abort: inst0 aborted in vector 2 settle");
        run(0, 4'b0111, full_len(0), 1'b0);
        $display("pass: inst0 after abort");

        // Asynchronous reset between edges during SAMPLE of vector 1.
        run(0, 4'b0001, 8, 1'b0);
        #1 rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check_all_zero("after_reset");
        run(0, 4'b0001, full_len(0), 1'b0);
        $display("reset: inst0 reset mid-sample then full pass");

        // Randomised gates, instances and busy-start injection.
        for (int r = 0; r < 8; r++) begin
            logic [3:0] tt;
            bit         inj;
            inst = int'($urandom_range(0, 1));
            tt   = 4'($urandom);
            inj  = 1'($urandom);
            run(inst, tt, full_len(inst), inj);
            $display("random: inst%0d gate=%b inject=%0d", inst, tt, inj);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles waited after driving a vector before sampling Y (legal range 0..15).
REQ-002 The module SHALL have parameter TRUTH, default 4'b0111, meaning the expected Y per vector index {A,B} (bit n = expected Y for A=n[1], B=n[0]; default is NAND).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one full 4-vector test pass; sampled only in IDLE.
REQ-006 abort  input  1  terminate a running pass.
REQ-007 Y  input  1  output of the gate under test.
REQ-008 A  output  1  gate input A, registered.
REQ-009 B  output  1  gate input B, registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at completion of a pass.
REQ-012 pass  output  1  high when the last completed pass had zero mismatches; held until next accepted start.
REQ-013 err_cnt  output  3  number of mismatching vectors in current/last pass (0..4).

Function
REQ-014 States SHALL be IDLE, APPLY, SETTLE, SAMPLE, DONE.
REQ-015 IDLE with start=1 SHALL go to APPLY on the next edge, clearing vector index idx to 0, err_cnt to 0 and pass to 0.
REQ-016 On every entry to APPLY, A SHALL load idx[1] and B SHALL load idx[0]; A/B SHALL hold that value until the next APPLY entry.
REQ-017 APPLY SHALL last exactly 1 cycle, then go to SETTLE if SETTLE_CYCLES>0, else directly to SAMPLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a 4-bit down-counter loaded in APPLY.
REQ-019 SAMPLE SHALL last 1 cycle, compare Y against TRUTH[idx], and increment err_cnt by 1 on mismatch.
REQ-020 From SAMPLE, idx<3 SHALL increment idx and go to APPLY; idx==3 SHALL go to DONE.
REQ-021 DONE SHALL last 1 cycle with done=1, set pass=1 iff final err_cnt (including last sample) is 0, then go to IDLE.
REQ-022 Latency from the cycle start is sampled to the done pulse SHALL be 4*(SETTLE_CYCLES+2)+1 cycles.
REQ-023 start while busy=1 SHALL be ignored; start held high in IDLE after DONE SHALL launch a new pass.
REQ-024 abort=1 in any non-IDLE state SHALL go to IDLE next edge with no done pulse, pass=0, err_cnt holding its value; abort has priority over all other transitions, and abort in IDLE has no effect.
REQ-025 After the pass ends (DONE or abort), A and B SHALL hold their last driven values.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, idx=0, settle counter=0, A=0, B=0, busy=0, done=0, pass=0, err_cnt=0, including mid-pass.
REQ-027 After rst deasserts, the first start SHALL behave identically to REQ-015.

Configuration
REQ-028 With macro GATE_TEST_SEQUENCER_ERRLOG_EN defined, the module SHALL add outputs first_err_idx (2 bits) and first_err_valid (1 bit): on the first mismatch of a pass, capture idx and set valid; both clear on accepted start and on reset.
REQ-029 Without GATE_TEST_SEQUENCER_ERRLOG_EN, those ports and their registers SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-030 NAND model on Y, defaults, start pulsed 1 cycle -> A/B step 00,01,10,11 every 4 cycles; done pulses 17 cycles after start; pass=1, err_cnt=0.
REQ-031 Y tied 0, TRUTH=4'b0111 -> err_cnt=3, pass=0 at done; ERRLOG build: first_err_idx=0, first_err_valid=1.
REQ-032 SETTLE_CYCLES=0, AND model, TRUTH=4'b1000 -> 2 cycles per vector, done 9 cycles after start, pass=1.
REQ-033 abort asserted during SETTLE of vector 2 -> IDLE next edge, no done, busy=0, pass=0, A=1, B=0 held; following start completes normally.
REQ-034 rst asserted mid-SAMPLE (async, between edges) -> all outputs 0 immediately; start pulsed during busy -> no restart, idx sequence unaffected.
